// File: rtl/char_stream_feeder_pkg.sv
// char_stream_feeder_pkg: shared character constants and the case-fold helper
//   FILL_DEFAULT            byte shown on char_out while starved
//   ASCII_UP_LO/ASCII_UP_HI uppercase range 'A'..'Z'
//   CASE_BIT                bit that separates upper from lower case
//   fold_char()             maps 'A'..'Z' to lowercase, passes other bytes through
package char_stream_feeder_pkg;
    localparam logic [7:0] FILL_DEFAULT = 8'h00;
    localparam logic [7:0] ASCII_UP_LO  = 8'h41;
    localparam logic [7:0] ASCII_UP_HI  = 8'h5A;
    localparam logic [7:0] CASE_BIT     = 8'h20;
    function automatic logic [7:0] fold_char(input logic [7:0] b);
        return (b >= ASCII_UP_LO && b <= ASCII_UP_HI) ? (b | CASE_BIT) : b;
    endfunction
endpackage

// File: rtl/char_stream_feeder_fifo.sv
// char_stream_feeder_fifo: synchronous byte FIFO with flush
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         synchronous flush, overrides push and pop
//   push, din   write request and byte (dropped when full)
//   pop, dout   read request and current head byte (ignored when empty)
//   full, empty occupancy flags taken from level
//   level       current occupancy, 0..DEPTH
module char_stream_feeder_fifo #(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        push,
    input  logic [7:0]  din,
    input  logic        pop,
    output logic [7:0]  dout,
    output logic        full,
    output logic        empty,
    output logic [AW:0] level
);
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;
    // Pointers alone cannot tell full from empty, so the flags come from level.
    assign full    = level == (AW+1)'(DEPTH);
    assign empty   = level == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/char_stream_feeder.sv
// char_stream_feeder: buffers producer bytes and presents one character per clock to the matcher
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         synchronous flush of FIFO and output register
//   in_valid, in_data, in_ready  producer handshake (in_ready = not full)
//   hold        freezes char_out/char_vld and the FIFO head
//   char_out    character to the matcher, FILL_CHAR when starved
//   char_vld    char_out carries real data
//   level       FIFO occupancy
module char_stream_feeder
    import char_stream_feeder_pkg::*;
#(
    parameter int         DEPTH     = 8,
    parameter logic [7:0] FILL_CHAR = FILL_DEFAULT,
    parameter bit         FOLD_CASE = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    output logic                   in_ready,
    input  logic                   hold,
    output logic [7:0]             char_out,
    output logic                   char_vld,
    output logic [$clog2(DEPTH):0] level
);
    logic [7:0] din, head;
    logic       full, empty;
    // Folding at write time keeps the output path a plain register.
    assign din      = FOLD_CASE ? fold_char(in_data) : in_data;
    assign in_ready = !full;
    char_stream_feeder_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .push  (in_valid),
        .din   (din),
        .pop   (!hold),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            char_out <= FILL_CHAR;
            char_vld <= 1'b0;
        end else if (clr) begin
            char_out <= FILL_CHAR;
            char_vld <= 1'b0;
        end else if (!hold) begin
            // A starved cycle shows FILL_CHAR so a partial match downstream breaks.
            char_out <= empty ? FILL_CHAR : head;
            char_vld <= !empty;
        end
    end
endmodule
